// File: rtl/deltasigma_mc.sv
// Multi-channel delta-sigma DAC modulator: shadowed codes, atomic commit on a shared tick.
// Optional macro DS_ORDER2_EN switches every channel from a first- to a second-order loop.
module deltasigma_mc #(
  parameter int BITS     = 5,
  parameter int CHANNELS = 4,
  parameter int DIV      = 1,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_chan,
  input  logic [BITS-1:0]     in_data,
  input  logic                commit,
  output logic                commit_pending,
  output logic                tick,
  output logic [CHANNELS-1:0] out
);

  localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [BITS-1:0] shadow_q [CHANNELS];
  logic [BITS-1:0] shadow_d [CHANNELS];
  logic [BITS-1:0] active_q [CHANNELS];
  logic [BITS-1:0] active_d [CHANNELS];
  logic            pend_q, pend_d;
  logic            chan_ok, accept, apply;

  generate
    if (DIV == 1) begin : g_tick_direct
      assign tick = enable;
    end else begin : g_tick_cnt
      logic [CNTW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (enable) cnt_d = (cnt_q == CNTW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign tick = enable && (cnt_q == CNTW'(DIV - 1));
    end

    // Out-of-range channel indices only exist when CHANNELS is not a power of two.
    if (CHANNELS == (1 << CW)) begin : g_chan_full
      assign chan_ok = 1'b1;
    end else begin : g_chan_part
      assign chan_ok = (in_chan < CW'(CHANNELS));
    end
  endgenerate

  assign in_ready       = !pend_q;
  assign commit_pending = pend_q;
  assign accept         = in_valid && !pend_q;
  assign apply          = pend_q && tick;

  always_comb begin
    pend_d = pend_q;
    if (apply)                 pend_d = 1'b0;
    else if (commit && !pend_q) pend_d = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = apply ? shadow_q[k] : active_q[k];
    end
    if (accept && chan_ok) shadow_d[in_chan] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
`ifdef DS_ORDER2_EN
      localparam int W1 = BITS + 3;
      localparam int W2 = BITS + 4;
      localparam logic [W1-1:0] MIN1 = {1'b1, {(W1-1){1'b0}}};
      localparam logic [W1-1:0] MAX1 = {1'b0, {(W1-1){1'b1}}};
      localparam logic [W2-1:0] MIN2 = {1'b1, {(W2-1){1'b0}}};
      localparam logic [W2-1:0] MAX2 = {1'b0, {(W2-1){1'b1}}};

      logic [W1-1:0] i1_q, i1_d;
      logic [W2-1:0] i2_q, i2_d;
      logic          out_q, out_d;
      logic [W1:0]   s1, act_x, fb1_x;
      logic [W2:0]   s2, i1_x, fb2_x;

      // Sums are formed one bit wider so overflow shows as a sign-bit disagreement.
      always_comb begin
        act_x = '0;
        act_x[BITS-1:0] = active_q[k];
        fb1_x = '0;
        fb1_x[BITS] = out_q;
        fb2_x = '0;
        fb2_x[BITS] = out_q;
        i1_x = {{2{i1_q[W1-1]}}, i1_q};
        s1 = {i1_q[W1-1], i1_q} + act_x - fb1_x;
        s2 = {i2_q[W2-1], i2_q} + i1_x - fb2_x;
        i1_d  = i1_q;
        i2_d  = i2_q;
        out_d = out_q;
        if (tick) begin
          if (s1[W1] != s1[W1-1]) i1_d = s1[W1] ? MIN1 : MAX1;
          else                    i1_d = s1[W1-1:0];
          if (s2[W2] != s2[W2-1]) i2_d = s2[W2] ? MIN2 : MAX2;
          else                    i2_d = s2[W2-1:0];
          out_d = !i2_d[W2-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          i1_q  <= '0;
          i2_q  <= '0;
          out_q <= 1'b0;
        end else begin
          i1_q  <= i1_d;
          i2_q  <= i2_d;
          out_q <= out_d;
        end
      end

      assign out[k] = out_q;
`else
      // Adding 3*2^BITS modulo 2^(BITS+2) is the -2^BITS feedback.
      localparam logic [BITS+1:0] FB = {2'b11, {BITS{1'b0}}};

      logic [BITS+1:0] acc_q, acc_d;

      always_comb begin
        acc_d = acc_q;
        if (tick) acc_d = acc_q + {2'b00, active_q[k]} + (acc_q[BITS+1] ? FB : '0);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
      end

      assign out[k] = acc_q[BITS+1];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_deltasigma_mc.sv
// Directed bench for deltasigma_mc: instance A (4 ch, DIV=1) for density, instance B
// (3 ch, DIV=4) for commit timing, channel range, enable freeze and async reset.
module tb_deltasigma_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       a_rst_n, a_en, a_iv, a_ir, a_cm, a_cp, a_tk;
  logic [1:0] a_ch;
  logic [4:0] a_dat;
  logic [3:0] a_out;
  logic       b_rst_n, b_en, b_iv, b_ir, b_cm, b_cp, b_tk;
  logic [1:0] b_ch;
  logic [4:0] b_dat;
  logic [2:0] b_out;

  logic [3:0] a_hist[$];
  logic [2:0] b_hist[$];
  int a_tmo, b_tmo;

  deltasigma_mc #(.BITS(5), .CHANNELS(4), .DIV(1)) u_a (
    .clk(clk), .rst_n(a_rst_n), .enable(a_en), .in_valid(a_iv), .in_ready(a_ir),
    .in_chan(a_ch), .in_data(a_dat), .commit(a_cm), .commit_pending(a_cp),
    .tick(a_tk), .out(a_out)
  );

  deltasigma_mc #(.BITS(5), .CHANNELS(3), .DIV(4)) u_b (
    .clk(clk), .rst_n(b_rst_n), .enable(b_en), .in_valid(b_iv), .in_ready(b_ir),
    .in_chan(b_ch), .in_data(b_dat), .commit(b_cm), .commit_pending(b_cp),
    .tick(b_tk), .out(b_out)
  );

  task automatic a_reset();
    a_rst_n = 1'b0; a_en = 1'b0; a_iv = 1'b0; a_cm = 1'b0; a_ch = '0; a_dat = '0;
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1; a_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic b_reset();
    b_rst_n = 1'b0; b_en = 1'b0; b_iv = 1'b0; b_cm = 1'b0; b_ch = '0; b_dat = '0;
    repeat (2) @(negedge clk);
    b_rst_n = 1'b1; b_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic a_write(input logic [1:0] ch, input logic [4:0] d, input logic cm);
    a_iv = 1'b1; a_ch = ch; a_dat = d; a_cm = cm;
    @(negedge clk);
    a_iv = 1'b0; a_cm = 1'b0;
  endtask

  task automatic b_write(input logic [1:0] ch, input logic [4:0] d, input logic cm);
    b_iv = 1'b1; b_ch = ch; b_dat = d; b_cm = cm;
    @(negedge clk);
    b_iv = 1'b0; b_cm = 1'b0;
  endtask

  task automatic a_wait_apply();
    int n = 0;
    while (a_cp && n < 50) begin @(negedge clk); n++; end
    if (a_cp) a_tmo++;
  endtask

  task automatic b_wait_apply();
    int n = 0;
    while (b_cp && n < 50) begin @(negedge clk); n++; end
    if (b_cp) b_tmo++;
  endtask

  // Records out as seen just after each of the next n tick edges.
  task automatic a_run_ticks(input int n);
    a_hist.delete();
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!a_tk && w < 20) begin @(negedge clk); w++; end
      if (!a_tk) a_tmo++;
      @(negedge clk);
      a_hist.push_back(a_out);
    end
  endtask

  task automatic b_run_ticks(input int n);
    b_hist.delete();
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!b_tk && w < 20) begin @(negedge clk); w++; end
      if (!b_tk) b_tmo++;
      @(negedge clk);
      b_hist.push_back(b_out);
    end
  endtask

  function automatic int a_ones(input int ch);
    int c = 0;
    for (int i = 0; i < a_hist.size(); i++) if (a_hist[i][ch]) c++;
    return c;
  endfunction

  function automatic int b_ones(input int ch);
    int c = 0;
    for (int i = 0; i < b_hist.size(); i++) if (b_hist[i][ch]) c++;
    return c;
  endfunction

  function automatic int b_first(input int ch);
    for (int i = 0; i < b_hist.size(); i++) if (b_hist[i][ch]) return i + 1;
    return 0;
  endfunction

  task automatic test_reset();
    a_rst_n = 1'b0; a_en = 1'b0; a_iv = 1'b0; a_cm = 1'b0; a_ch = '0; a_dat = '0;
    b_rst_n = 1'b0; b_en = 1'b0; b_iv = 1'b0; b_cm = 1'b0; b_ch = '0; b_dat = '0;
    @(negedge clk);
    checks++; if (a_out !== 4'b0000) begin failures++; $display("FAIL reset_a_out: got %b want 0000", a_out); end
    checks++; if (a_ir !== 1'b1 || a_cp !== 1'b0) begin failures++; $display("FAIL reset_a_hs: ready=%b pending=%b want 1/0", a_ir, a_cp); end
    checks++; if (a_tk !== 1'b0) begin failures++; $display("FAIL reset_a_tick: got %b want 0", a_tk); end
    checks++; if (b_out !== 3'b000) begin failures++; $display("FAIL reset_b_out: got %b want 000", b_out); end
    checks++; if (b_ir !== 1'b1 || b_cp !== 1'b0) begin failures++; $display("FAIL reset_b_hs: ready=%b pending=%b want 1/0", b_ir, b_cp); end
    checks++; if (b_tk !== 1'b0) begin failures++; $display("FAIL reset_b_tick: got %b want 0", b_tk); end
  endtask

  task automatic test_density();
    a_tmo = 0;
    a_reset();
    a_write(2'd0, 5'd8, 1'b1);
    a_wait_apply();
    a_run_ticks(128);
    checks++; if (a_tmo != 0) begin failures++; $display("FAIL density_timeout: got %0d want 0", a_tmo); end
    checks++; if (a_ones(0) < 31 || a_ones(0) > 33) begin failures++; $display("FAIL density_ch0: got %0d want 32+-1", a_ones(0)); end
    checks++; if (a_ones(1) + a_ones(2) + a_ones(3) != 0) begin failures++; $display("FAIL density_others: got %0d want 0", a_ones(1) + a_ones(2) + a_ones(3)); end
  endtask

  task automatic test_full_scale();
    a_tmo = 0;
    a_reset();
    a_write(2'd0, 5'd31, 1'b0);
    a_write(2'd1, 5'd31, 1'b0);
    a_write(2'd2, 5'd31, 1'b0);
    a_write(2'd3, 5'd31, 1'b1);
    a_wait_apply();
    a_run_ticks(128);
    checks++; if (a_tmo != 0) begin failures++; $display("FAIL full_timeout: got %0d want 0", a_tmo); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_ones(k) < 123 || a_ones(k) > 125) begin failures++; $display("FAIL full_ch%0d: got %0d want 124+-1", k, a_ones(k)); end
    end
  endtask

  task automatic test_zero();
    a_tmo = 0;
    a_reset();
    a_write(2'd0, 5'd0, 1'b1);
    a_wait_apply();
    a_run_ticks(64);
    checks++; if (a_tmo != 0) begin failures++; $display("FAIL zero_timeout: got %0d want 0", a_tmo); end
    checks++; if (a_ones(0) + a_ones(1) + a_ones(2) + a_ones(3) != 0) begin failures++; $display("FAIL zero_out: got %0d ones want 0", a_ones(0) + a_ones(1) + a_ones(2) + a_ones(3)); end
    checks++; if (a_ir !== 1'b1 || a_cp !== 1'b0) begin failures++; $display("FAIL zero_hs: ready=%b pending=%b want 1/0", a_ir, a_cp); end
  endtask

  task automatic test_commit_timing();
    int w = 0;
    b_tmo = 0;
    b_reset();
    b_write(2'd0, 5'd16, 1'b0);
    while (!b_tk && w < 20) begin @(negedge clk); w++; end
    if (!b_tk) b_tmo++;
    @(negedge clk);
    @(negedge clk);
    b_cm = 1'b1;
    @(negedge clk);
    b_cm = 1'b0;
    checks++; if (b_cp !== 1'b1 || b_ir !== 1'b0) begin failures++; $display("FAIL pend_cyc1: pending=%b ready=%b want 1/0", b_cp, b_ir); end
    b_iv = 1'b1; b_ch = 2'd1; b_dat = 5'd31;
    @(negedge clk);
    checks++; if (b_cp !== 1'b1 || b_ir !== 1'b0 || b_tk !== 1'b1) begin failures++; $display("FAIL pend_cyc2: pending=%b ready=%b tick=%b want 1/0/1", b_cp, b_ir, b_tk); end
    @(negedge clk);
    b_iv = 1'b0;
    checks++; if (b_cp !== 1'b0 || b_ir !== 1'b1) begin failures++; $display("FAIL pend_clear: pending=%b ready=%b want 0/1", b_cp, b_ir); end
    b_run_ticks(16);
    checks++; if (b_tmo != 0) begin failures++; $display("FAIL timing_timeout: got %0d want 0", b_tmo); end
    checks++; if (b_first(0) != 4) begin failures++; $display("FAIL timing_first: got tick %0d want 4", b_first(0)); end
    checks++; if (b_ones(0) != 7) begin failures++; $display("FAIL timing_ch0: got %0d want 7", b_ones(0)); end
    checks++; if (b_ones(1) != 0) begin failures++; $display("FAIL timing_rejected_write: got %0d want 0", b_ones(1)); end
  endtask

  task automatic test_write_commit_same();
    b_tmo = 0;
    b_reset();
    b_write(2'd2, 5'd5, 1'b1);
    b_wait_apply();
    b_run_ticks(60);
    checks++; if (b_tmo != 0) begin failures++; $display("FAIL same_timeout: got %0d want 0", b_tmo); end
    checks++; if (b_first(2) != 13) begin failures++; $display("FAIL same_first: got tick %0d want 13", b_first(2)); end
    checks++; if (b_ones(2) != 8) begin failures++; $display("FAIL same_ch2: got %0d want 8", b_ones(2)); end
    checks++; if (b_ones(0) + b_ones(1) != 0) begin failures++; $display("FAIL same_others: got %0d want 0", b_ones(0) + b_ones(1)); end
  endtask

  task automatic test_bad_chan();
    b_tmo = 0;
    b_reset();
    checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL badch_ready: got %b want 1", b_ir); end
    b_write(2'd3, 5'd31, 1'b1);
    checks++; if (b_cp !== 1'b1) begin failures++; $display("FAIL badch_pending: got %b want 1", b_cp); end
    b_wait_apply();
    b_run_ticks(40);
    checks++; if (b_tmo != 0) begin failures++; $display("FAIL badch_timeout: got %0d want 0", b_tmo); end
    checks++; if (b_ones(0) + b_ones(1) + b_ones(2) != 0) begin failures++; $display("FAIL badch_out: got %0d ones want 0", b_ones(0) + b_ones(1) + b_ones(2)); end
  endtask

  task automatic test_enable();
    int bad = 0;
    b_tmo = 0;
    b_reset();
    b_write(2'd0, 5'd16, 1'b1);
    b_wait_apply();
    b_run_ticks(6);
    checks++; if (b_out !== 3'b001) begin failures++; $display("FAIL en_pre: got %b want 001", b_out); end
    @(negedge clk);
    b_en = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (b_tk !== 1'b0 || b_out !== 3'b001) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL en_frozen: got %0d bad cycles want 0", bad); end
    b_en = 1'b1;
    @(negedge clk);
    checks++; if (b_tk !== 1'b0) begin failures++; $display("FAIL en_resume_cnt2: tick=%b want 0", b_tk); end
    @(negedge clk);
    checks++; if (b_tk !== 1'b1) begin failures++; $display("FAIL en_resume_cnt3: tick=%b want 1", b_tk); end
    @(negedge clk);
    checks++; if (b_out !== 3'b000) begin failures++; $display("FAIL en_k7: got %b want 000", b_out); end
    b_run_ticks(1);
    checks++; if (b_tmo != 0 || b_out !== 3'b001) begin failures++; $display("FAIL en_k8: got %b tmo=%0d want 001 tmo=0", b_out, b_tmo); end
  endtask

  task automatic test_reset_mid_commit();
    b_tmo = 0;
    b_reset();
    b_write(2'd0, 5'd16, 1'b1);
    b_wait_apply();
    b_run_ticks(6);
    b_write(2'd1, 5'd31, 1'b1);
    checks++; if (b_cp !== 1'b1 || b_out !== 3'b001) begin failures++; $display("FAIL rst_pre: pending=%b out=%b want 1/001", b_cp, b_out); end
    #2;
    b_rst_n = 1'b0;
    #1;
    checks++; if (b_out !== 3'b000 || b_cp !== 1'b0 || b_ir !== 1'b1 || b_tk !== 1'b0) begin
      failures++; $display("FAIL rst_async: out=%b pending=%b ready=%b tick=%b want 000/0/1/0", b_out, b_cp, b_ir, b_tk);
    end
    @(negedge clk);
    b_rst_n = 1'b1;
    b_run_ticks(12);
    checks++; if (b_ones(0) + b_ones(1) + b_ones(2) != 0) begin failures++; $display("FAIL rst_lost: got %0d ones want 0", b_ones(0) + b_ones(1) + b_ones(2)); end
    b_write(2'd0, 5'd16, 1'b1);
    b_wait_apply();
    b_run_ticks(4);
    checks++; if (b_tmo != 0) begin failures++; $display("FAIL rst_timeout: got %0d want 0", b_tmo); end
    checks++; if (b_hist[2] !== 3'b000 || b_hist[3] !== 3'b001) begin failures++; $display("FAIL rst_recommit: k3=%b k4=%b want 000/001", b_hist[2], b_hist[3]); end
  endtask

  initial begin
    test_reset();
    test_density();
    test_full_scale();
    test_zero();
    test_commit_timing();
    test_write_commit_same();
    test_bad_chan();
    test_enable();
    test_reset_mid_commit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/deltasigma_mc.md
# deltasigma_mc

Multi-channel, parametrised delta-sigma DAC modulator: successor to the single-channel first-order modulator in the PWM output path. It holds CHANNELS independent modulators sharing one internally generated modulator tick. New codes arrive through a valid/ready write port into per-channel shadow registers and are committed to all channels atomically on a tick boundary. A compile-time option upgrades every channel from a first-order to a second-order loop.

## Interface
- BITS, 5: input code width; output density = code / 2^BITS.
- CHANNELS, 4: number of modulators, ≥1.
- DIV, 1: clock cycles per modulator tick, ≥1.
- CW, $clog2(CHANNELS) (min 1): derived, channel index width.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run tick counter and modulators; low freezes all modulator state.
- in_valid  in  1  write request.
- in_ready  out  1  write accepted when in_valid && in_ready.
- in_chan  in  CW  target channel.
- in_data  in  BITS  code for target channel.
- commit  in  1  request transfer of all shadows to active codes.
- commit_pending  out  1  commit requested, not yet applied.
- tick  out  1  high in the cycle whose closing edge updates the modulators.
- out  out  CHANNELS  modulator bitstreams, bit k = channel k, registered.

## Operation
- Reset: shadow, active, integrators, tick counter = 0; out = 0; tick = 0; commit_pending = 0; in_ready = 1.
- Tick generator: counter cnt 0..DIV-1; tick = enable && cnt == DIV-1; cnt advances only when enable, wraps to 0 after DIV-1. DIV=1: tick = enable.
- Write: on accepted handshake shadow[in_chan] <= in_data. in_chan ≥ CHANNELS: handshake completes, data discarded.
- in_ready = !commit_pending; shadows are frozen while a commit waits.
- Commit: commit && !commit_pending sets commit_pending. On the first tick edge with commit_pending=1, active[k] <= shadow[k] for all k and commit_pending clears. commit while pending: ignored.
- Write and commit same cycle (pending low): write accepted and included in the commit.
- First-order channel (default): unsigned accumulator acc, BITS+2 bits. out[k] = acc[BITS+1]. On tick: acc <= acc + active + (out[k] ? 3·2^BITS : 0), modulo 2^(BITS+2); the +3·2^BITS term is −2^BITS feedback.
- Modulators on a commit tick use the pre-commit active value; new code affects the following tick.
- enable low: counter, integrators and out hold; writes and commit requests still accepted; pending commit waits for next tick.

## Timing
- Write-to-shadow: 1 cycle. Commit-to-active: ≥1 cycle, ≤ DIV cycles after commit is sampled (plus any time enable is low).
- out changes only on tick edges; visible the cycle after tick is high.
- First new-code effect on out: second tick edge after commit is applied.
- rst_n asserted at any time, including mid-commit: immediate return to reset values; pending commit lost.

## Configuration
- DS_ORDER2_EN defined: each channel is second-order. Signed integrators i1 (BITS+3 bits) and i2 (BITS+4 bits), fb = out[k] ? 2^BITS : 0, out[k] = !i2[msb] (i2 ≥ 0). On tick, using pre-edge values: i1 <= sat(i1 + active − fb); i2 <= sat(i2 + i1 − fb); sat clamps to the register's signed range. Reset: i1 = i2 = 0, so out = 1 after reset release only via i2 ≥ 0 → out register forced 0 in reset, and out = !i2[msb] applied from the first tick.
- Undefined: first-order loop only; no i2 logic. Ports and handshake identical in both builds.

## Test plan
- BITS=5, DIV=1, write ch0=8, commit, run 128 ticks after first change -> ch0 ones count 32±1; other channels all 0.
- Code 0 on all channels -> out stays 0 forever; code 31 -> ones count 124±1 over 128 ticks (first-order; same ±2 with DS_ORDER2_EN).
- DIV=4: commit at cnt=1 -> commit_pending high 2 cycles, in_ready low same cycles; active loads on tick; in_valid during pending not accepted.
- Write ch2=5 and commit same cycle -> ch2 uses 5 after commit; write with in_chan=CHANNELS (non-power-of-2 CHANNELS=3) -> no shadow changes.
- enable low for 20 cycles mid-run -> out, cnt frozen, tick=0; pattern resumes exactly where halted.
- rst_n pulse while commit_pending=1 and integrators non-zero -> all outputs at reset values asynchronously, in_ready=1, next commit required to load codes.
